multiport_regfile: RTL

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

---
 rtl/multiport_regfile.sv | 116 +++++++++++
 1 files changed

// File: rtl/multiport_regfile.sv
`default_nettype none
// ============================================================================
// Module   : multiport_regfile
// Brief    : Register file with NRD read ports, scoreboard pending bits, and a
//            zeroing sweep. Optional macro REGFILE_BYPASS_EN adds write-to-read
//            forwarding in the same cycle.
// Revision : 1.0
// ============================================================================
module multiport_regfile #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rs_sel,
  input  logic [NRD-1:0]      rs_en,
  output logic [NRD*XLEN-1:0] rs_out,
  output logic [NRD-1:0]      rs_pending,
  input  logic                rd_w,
  input  logic [AW-1:0]       rd_sel,
  input  logic [XLEN-1:0]     rd_in,
  input  logic                issue_v,
  input  logic [AW-1:0]       issue_sel,
  input  logic                clear_req,
  output logic                ready
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [AW-1:0] c_first_idx = AW'(1);
  localparam logic [AW-1:0] c_last_idx  = AW'(NREGS - 1);

  state_t           r_state;
  logic [AW-1:0]    r_sweep_idx;
  logic [NREGS-1:0] r_pending;
  logic             r_ready;
  logic [XLEN-1:0]  r_regs [NREGS];

  logic w_wr_ok;
  logic w_iss_ok;

  assign w_wr_ok  = (r_state == ST_READY) && rd_w    && (rd_sel    != '0);
  assign w_iss_ok = (r_state == ST_READY) && issue_v && (issue_sel != '0);
  assign ready    = r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_CLEAR;
      r_sweep_idx <= c_first_idx;
      r_pending   <= '0;
      r_ready     <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_sweep_idx == c_last_idx) begin
            r_state     <= ST_READY;
            r_ready     <= 1'b1;
            r_sweep_idx <= c_first_idx;
          end else begin
            r_sweep_idx <= r_sweep_idx + c_first_idx;
          end
        end
        ST_READY: begin
          if (clear_req) begin
            r_state     <= ST_CLEAR;
            r_ready     <= 1'b0;
            r_sweep_idx <= c_first_idx;
            r_pending   <= '0;
          end else begin
            // Issue is applied last so it wins over a same-index writeback.
            if (w_wr_ok)  r_pending[rd_sel]    <= 1'b0;
            if (w_iss_ok) r_pending[issue_sel] <= 1'b1;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  // Storage has no reset; the sweep is what zeroes it. Entry 0 is never written.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_regs[r_sweep_idx] <= '0;
    end else if (w_wr_ok) begin
      r_regs[rd_sel] <= rd_in;
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] w_sel;
      logic          w_act;
      logic          w_byp;

      assign w_sel = rs_sel[gi*AW +: AW];
      assign w_act = r_ready && rs_en[gi] && (w_sel != '0);
`ifdef REGFILE_BYPASS_EN
      assign w_byp = w_wr_ok && (w_sel == rd_sel);
`else
      assign w_byp = 1'b0;
`endif
      assign rs_out[gi*XLEN +: XLEN] = !w_act ? '0 :
                                       w_byp  ? rd_in : r_regs[w_sel];
      assign rs_pending[gi] = w_act &&
                              (w_byp ? (w_iss_ok && (issue_sel == w_sel))
                                     : r_pending[w_sel]);
    end
  endgenerate

endmodule
`default_nettype wire
